// File: rtl/lc3_disp_pkg.sv
// Shared display constants for the LC3 board: seven-segment font, digit
// geometry, register-select codes and the display payload type.
package lc3_disp_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;
   localparam int unsigned SEL_W      = 4;
   localparam int unsigned SEG_W      = 8;

   // Active-high segment encodings, bit order {dp,g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;
   localparam logic [SEG_W-1:0] FONT [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   typedef enum logic [SEL_W-1:0] {
      SEL_R0  = 4'b0000,
      SEL_R1  = 4'b0001,
      SEL_R2  = 4'b0010,
      SEL_R3  = 4'b0011,
      SEL_R4  = 4'b0100,
      SEL_R5  = 4'b0101,
      SEL_R6  = 4'b0110,
      SEL_R7  = 4'b0111,
      SEL_PC  = 4'b1000,
      SEL_MAR = 4'b1001,
      SEL_MDR = 4'b1010,
      SEL_IR  = 4'b1011
   } reg_sel_e;

   typedef struct packed {
      logic [VAL_W-1:0] value;
      logic [SEL_W-1:0] sel;
   } disp_word_t;

endpackage

// File: rtl/lc3_hex7seg.sv
// Combinational nibble-to-seven-segment decoder (active-high) with blanking.
module lc3_hex7seg
   import lc3_disp_pkg::*;
(
   input  logic [NIB_W-1:0] nib_i,
   input  logic             blank_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      if (!blank_i) begin
         seg_o = FONT[nib_i];
      end
   end

endmodule

// File: rtl/lc3_seg_scan.sv
// Multiplexed 4-digit seven-segment scanner with frame-aligned, tear-free
// display updates and optional leading-zero blanking.
module lc3_seg_scan
   import lc3_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [VAL_W-1:0]      disp_value,
   input  logic [SEL_W-1:0]      disp_sel,
   input  logic                  disp_load,
   input  logic                  blank_lz,
   output logic [SEG_W-1:0]      seg_output_single,
   output logic [NUM_DIGITS-1:0] seg_output_sequence,
   output logic [SEL_W-1:0]      led_output,
   output logic                  frame_done
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned DIG_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
   localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   disp_word_t            disp_q, disp_d;
   disp_word_t            pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [NUM_DIGITS-1:0] seq_q, seq_d;
   logic [SEL_W-1:0]      led_q, led_d;
   logic                  fd_q, fd_d;

   logic                  frame_end_c;
   logic                  dead_c;
   logic                  upper_zero_c;
   logic [NIB_W-1:0]      nib_c;
   logic [SEG_W-1:0]      hex_seg_c;
   logic [NUM_DIGITS-1:0] onehot_c;
   disp_word_t            incoming_c;

   assign frame_end_c  = (dig_q == DIG_LAST) && (cnt_q == CNT_MAX);
   assign dead_c       = (cnt_q == '0);
   assign incoming_c   = '{value: disp_value, sel: disp_sel};
   assign nib_c        = disp_q.value[{dig_q, 2'b00} +: NIB_W];
   // Digit n is a leading zero when nibble n and all nibbles above it are zero
   assign upper_zero_c = (dig_q != '0) && ((disp_q.value >> {dig_q, 2'b00}) == '0);
   assign onehot_c     = NUM_DIGITS'(1) << dig_q;

   lc3_hex7seg u_hex (
      .nib_i   (nib_c),
      .blank_i (dead_c || (blank_lz && upper_zero_c)),
      .seg_o   (hex_seg_c)
   );

   // Scan position, pending buffer and frame-boundary commit
   always_comb begin
      cnt_d      = cnt_q;
      dig_d      = dig_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;

      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         dig_d = dig_q + DIG_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (frame_end_c) begin
         if (disp_load) begin
            disp_d     = incoming_c;
            pend_vld_d = 1'b0;
         end else if (pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
         end
      end else if (disp_load) begin
         pend_d     = incoming_c;
         pend_vld_d = 1'b1;
      end
   end

   // Output drive derived from the current scan state
   always_comb begin
      seg_d = SEG_ACTIVE_LOW ? ~hex_seg_c : hex_seg_c;
      seq_d = dead_c ? DIG_IDLE : (DIG_ACTIVE_LOW ? ~onehot_c : onehot_c);
      led_d = disp_q.sel;
      fd_d  = frame_end_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         dig_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= SEG_IDLE;
         seq_q      <= DIG_IDLE;
         led_q      <= '0;
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dig_q      <= dig_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= seg_d;
         seq_q      <= seq_d;
         led_q      <= led_d;
         fd_q       <= fd_d;
      end
   end

   assign seg_output_single   = seg_q;
   assign seg_output_sequence = seq_q;
   assign led_output          = led_q;
   assign frame_done          = fd_q;

endmodule
